// File: rtl/hack_pkg.sv
// Shared types and sizes for the Hack boot loader.
// Holds the loader FSM encoding, the ROM geometry and the default ROM depth.
package hack_pkg;

    localparam int ROM_AW        = 15;
    localparam int WORD_W        = 16;
    localparam int LDR_MAX_WORDS = 32768;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DAT_HI,
        ST_DAT_LO,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Pairs stream bytes into big-endian words and presents registered ROM writes.
// Ports: clk_i, reset_ni, hi_en_i/lo_en_i (byte strobes), byte_i, addr_i -> wr_en_o, addr_o, data_o.
module word_assembler
    import hack_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              hi_en_i,
    input  logic              lo_en_i,
    input  logic [7:0]        byte_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic              wr_en_o,
    output logic [ROM_AW-1:0] addr_o,
    output logic [WORD_W-1:0] data_o
);

    logic [7:0]        r_hi;
    logic              r_wr;
    logic [ROM_AW-1:0] r_addr;
    logic [WORD_W-1:0] r_data;

    // Address and data only move on a write, so they hold between pulses.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_hi   <= '0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_wr <= lo_en_i;
            if (hi_en_i) begin
                r_hi <= byte_i;
            end
            if (lo_en_i) begin
                r_data <= {r_hi, byte_i};
                r_addr <= addr_i;
            end
        end
    end

    assign wr_en_o = r_wr;
    assign addr_o  = r_addr;
    assign data_o  = r_data;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: byte stream -> instruction ROM write port, holding the CPU in reset until loaded.
// Ports: clk_i, reset_ni, byte_i/byte_valid_i/byte_ready_o, restart_i, rom_wr_en_o/rom_addr_o/rom_data_o, cpu_reset_o, done_o, err_o.
module rom_loader
    import hack_pkg::*;
#(
    parameter int MAX_WORDS = LDR_MAX_WORDS
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              restart_i,
    output logic              rom_wr_en_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic [WORD_W-1:0] rom_data_o,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [WORD_W:0] LP_MAX = MAX_WORDS[WORD_W:0];

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [WORD_W-1:0] r_cnt;
    logic [ROM_AW-1:0] r_idx;
    logic              w_ready;
    logic              w_acc;
    logic              w_last;
    logic              w_hi_en;
    logic              w_lo_en;
    logic [WORD_W-1:0] w_n;

    assign w_ready = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) ||
                     (r_state == ST_DAT_HI) || (r_state == ST_DAT_LO);
    assign w_acc   = byte_valid_i & w_ready;
    // Full count as it will be once the low header byte lands.
    assign w_n     = {r_cnt[15:8], byte_i};
    // Index is compared against N-1 so a full-depth count still fits ROM_AW bits.
    assign w_last  = ({1'b0, r_idx} == (r_cnt - 16'd1));

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_hi_en = 1'b0;
        w_lo_en = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_next = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_acc) w_next = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_acc) begin
                    if (w_n == '0) begin
                        w_next = ST_RUN;
                    end else if ({1'b0, w_n} > LP_MAX) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (w_acc) begin
                    w_hi_en = 1'b1;
                    w_next  = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (w_acc) begin
                    w_lo_en = 1'b1;
                    w_next  = w_last ? ST_RUN : ST_DAT_HI;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (restart_i) w_next = ST_INIT;
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_cnt <= '0;
                r_idx <= '0;
            end
            if (r_state == ST_HDR_HI && w_acc) r_cnt[15:8] <= byte_i;
            if (r_state == ST_HDR_LO && w_acc) r_cnt[7:0]  <= byte_i;
            if (w_lo_en) r_idx <= r_idx + 1'b1;
        end
    end

    word_assembler u_asm (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .hi_en_i  (w_hi_en),
        .lo_en_i  (w_lo_en),
        .byte_i   (byte_i),
        .addr_i   (r_idx),
        .wr_en_o  (rom_wr_en_o),
        .addr_o   (rom_addr_o),
        .data_o   (rom_data_o)
    );

    // The CPU is released on the same edge that enters RUN, i.e. with the last write.
    assign byte_ready_o = w_ready;
    assign cpu_reset_o  = (r_state != ST_RUN);
    assign done_o       = (r_state == ST_RUN);
    assign err_o        = (r_state == ST_ERROR);

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected ROM writes are queued as bytes are sent.
// A negedge monitor records every write; each scenario task drains and compares.
module tb_rom_loader;
    import hack_pkg::*;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
        int          c;
    } obs_t;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        restart_i = 1'b0;
    logic        rom_wr_en_o;
    logic [14:0] rom_addr_o;
    logic [15:0] rom_data_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];

    rom_loader #(.MAX_WORDS(32768)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .restart_i    (restart_i),
        .rom_wr_en_o  (rom_wr_en_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_o   (rom_data_o),
        .cpu_reset_o  (cpu_reset_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (rom_wr_en_o === 1'b1) obs_q.push_back('{rom_addr_o, rom_data_o, cyc});
    end

    task automatic push(input logic [14:0] a, input logic [15:0] d);
        exp_q.push_back('{a, d});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        @(negedge clk_i);
        while (byte_ready_o !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        if (byte_ready_o !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: ready=%b required 1", byte_ready_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_restart();
        byte_valid_i = 1'b0;
        restart_i = 1'b1;
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        vectors++;
        if ({byte_ready_o, rom_wr_en_o, cpu_reset_o, done_o, err_o} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_flags: rdy/wr/cpu/done/err=%b required 00100",
                     {byte_ready_o, rom_wr_en_o, cpu_reset_o, done_o, err_o});
        end
        vectors++;
        if (rom_addr_o !== 15'd0 || rom_data_o !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_port: addr=%h data=%h required 0/0", rom_addr_o, rom_data_o);
        end
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        vectors++;
        if (byte_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL init_one_cycle: ready=%b required 1", byte_ready_o);
        end
    endtask

    task automatic test_nominal();
        obs_t o;
        exp_t e;
        int   prev;
        push(15'd0, 16'h1234);
        push(15'd1, 16'hABCD);
        push(15'd2, 16'h0007);
        send_word(16'h0003);
        send_word(16'h1234);
        send_word(16'hABCD);
        send_word(16'h0007);
        vectors++;
        if ({rom_wr_en_o, cpu_reset_o, done_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL nominal_release: wr/cpu/done=%b required 101",
                     {rom_wr_en_o, cpu_reset_o, done_o});
        end
        byte_i = 8'hFF;
        byte_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
        vectors++;
        if ({byte_ready_o, done_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL run_ignores: ready/done=%b required 01", {byte_ready_o, done_o});
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL nominal_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        prev = -1;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.a !== e.a || o.d !== e.d) begin
                miscompares++;
                $display("FAIL nominal_write: got %h@%h required %h@%h", o.d, o.a, e.d, e.a);
            end
            if (prev >= 0) begin
                vectors++;
                if (o.c - prev != 2) begin
                    miscompares++;
                    $display("FAIL nominal_spacing: gap=%0d required 2", o.c - prev);
                end
            end
            prev = o.c;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reload();
        exp_t e;
        obs_t o;
        pulse_restart();
        vectors++;
        if ({cpu_reset_o, done_o, byte_ready_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL reload_edge: cpu/done/ready=%b required 100",
                     {cpu_reset_o, done_o, byte_ready_o});
        end
        @(posedge clk_i);
        #1;
        vectors++;
        if (byte_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_ready: ready=%b required 1", byte_ready_o);
        end
        push(15'd0, 16'h5AA5);
        send_word(16'h0001);
        send_word(16'h5AA5);
        vectors++;
        if ({rom_wr_en_o, cpu_reset_o, done_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL reload_release: wr/cpu/done=%b required 101",
                     {rom_wr_en_o, cpu_reset_o, done_o});
        end
        idle(3);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL reload_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.a !== e.a || o.d !== e.d) begin
                miscompares++;
                $display("FAIL reload_write: got %h@%h required %h@%h", o.d, o.a, e.d, e.a);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_empty();
        pulse_restart();
        send_word(16'h0000);
        vectors++;
        if ({done_o, cpu_reset_o, rom_wr_en_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL empty_run: done/cpu/wr=%b required 100",
                     {done_o, cpu_reset_o, rom_wr_en_o});
        end
        idle(3);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL empty_writes: writes=%0d required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_illegal();
        pulse_restart();
        send_word(16'h8001);
        vectors++;
        if ({err_o, cpu_reset_o, byte_ready_o, done_o} !== 4'b1100) begin
            miscompares++;
            $display("FAIL illegal_err: err/cpu/ready/done=%b required 1100",
                     {err_o, cpu_reset_o, byte_ready_o, done_o});
        end
        idle(2);
        vectors++;
        if ({err_o, byte_ready_o, obs_q.size() == 0} !== 3'b101) begin
            miscompares++;
            $display("FAIL illegal_hold: err/ready/nowr=%b required 101",
                     {err_o, byte_ready_o, obs_q.size() == 0});
        end
        pulse_restart();
        vectors++;
        if ({err_o, byte_ready_o, cpu_reset_o} !== 3'b001) begin
            miscompares++;
            $display("FAIL illegal_init: err/ready/cpu=%b required 001",
                     {err_o, byte_ready_o, cpu_reset_o});
        end
        @(posedge clk_i);
        #1;
        vectors++;
        if (byte_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_hdr: ready=%b required 1", byte_ready_o);
        end
        obs_q.delete();
    endtask

    task automatic test_stall();
        exp_t e;
        obs_t o;
        int   bad;
        push(15'd0, 16'h1111);
        push(15'd1, 16'h2233);
        send_word(16'h0002);
        send_word(16'h1111);
        send_byte(8'h22);
        byte_valid_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (rom_wr_en_o !== 1'b0) bad++;
            @(posedge clk_i);
            #1;
        end
        vectors++;
        if (bad != 0 || obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL stall_quiet: stall_writes=%0d total=%0d required 0/1", bad, obs_q.size());
        end
        send_byte(8'h33);
        vectors++;
        if ({rom_wr_en_o, cpu_reset_o} !== 2'b10 || rom_addr_o !== 15'd1 || rom_data_o !== 16'h2233) begin
            miscompares++;
            $display("FAIL stall_write: wr/cpu=%b %h@%h required 10 2233@0001",
                     {rom_wr_en_o, cpu_reset_o}, rom_data_o, rom_addr_o);
        end
        idle(2);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.a !== e.a || o.d !== e.d) begin
                miscompares++;
                $display("FAIL stall_data: got %h@%h required %h@%h", o.d, o.a, e.d, e.a);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        pulse_restart();
        push(15'd0, 16'h0101);
        push(15'd1, 16'h0202);
        push(15'd2, 16'h0303);
        send_word(16'h0005);
        send_word(16'h0101);
        send_word(16'h0202);
        send_word(16'h0303);
        byte_valid_i = 1'b0;
        reset_ni = 1'b0;
        @(posedge clk_i);
        #1;
        vectors++;
        if ({byte_ready_o, rom_wr_en_o, cpu_reset_o, done_o, err_o} !== 5'b00100 ||
            rom_addr_o !== 15'd0 || rom_data_o !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_vals: flags=%b %h@%h required 00100 0000@0000",
                     {byte_ready_o, rom_wr_en_o, cpu_reset_o, done_o, err_o}, rom_data_o, rom_addr_o);
        end
        reset_ni = 1'b1;
        push(15'd0, 16'hBEEF);
        push(15'd1, 16'hCAFE);
        send_word(16'h0002);
        send_word(16'hBEEF);
        vectors++;
        if (cpu_reset_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_held: cpu=%b required 1", cpu_reset_o);
        end
        send_word(16'hCAFE);
        vectors++;
        if ({rom_wr_en_o, cpu_reset_o, done_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL midreset_release: wr/cpu/done=%b required 101",
                     {rom_wr_en_o, cpu_reset_o, done_o});
        end
        idle(2);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL midreset_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.a !== e.a || o.d !== e.d) begin
                miscompares++;
                $display("FAIL midreset_write: got %h@%h required %h@%h", o.d, o.a, e.d, e.a);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reload();
        test_empty();
        test_illegal();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
